// File: rtl/switch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : switch_sync_fifo
// Purpose  : Synchronous port-queue FIFO with occupancy count, programmable
//            almost flags, sticky error flags and a read-data valid strobe.
//            Define SWITCH_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision : 1.0
// ============================================================================
module switch_sync_fifo #(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          read_en,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_afull  = c_cnt_w'(AFULL_THRESH);
  localparam logic [c_cnt_w-1:0] c_aempty = c_cnt_w'(AEMPTY_THRESH);

  if ((FIFO_DEPTH < 4) || ((1 << c_addr_w) != FIFO_DEPTH) ||
      (AEMPTY_THRESH < 1) || (AEMPTY_THRESH >= AFULL_THRESH) ||
      (AFULL_THRESH > FIFO_DEPTH - 1) || (FIFO_WIDTH < 1)) begin : g_bad_params
    $error("switch_sync_fifo: illegal parameter combination");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [c_addr_w-1:0] wptr_q, rptr_q;
  logic [c_cnt_w-1:0]  count_q, count_d;
  logic                empty_q, full_q, aempty_q, afull_q;
  logic                overflow_q, underflow_q;
  logic                w_rd_acc, w_wr_acc;

  // A write at full may proceed only by reusing the slot freed by a read;
  // a read at empty never bypasses a same-cycle write.
  assign w_rd_acc = read_en & ~empty_q;
  assign w_wr_acc = write_en & (~full_q | w_rd_acc);
  assign count_d  = count_q + c_cnt_w'(w_wr_acc) - c_cnt_w'(w_rd_acc);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      mem[wptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      aempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_wr_acc) wptr_q <= wptr_q + c_addr_w'(1);
      if (w_rd_acc) rptr_q <= rptr_q + c_addr_w'(1);
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == c_depth);
      aempty_q <= (count_d <= c_aempty);
      afull_q  <= (count_d >= c_afull);
      if (write_en && !w_wr_acc) overflow_q  <= 1'b1;
      if (read_en  && !w_rd_acc) underflow_q <= 1'b1;
    end
  end

`ifdef SWITCH_FIFO_FWFT_EN
  // Head word is presented straight from storage; zero while nothing is queued.
  assign data_out   = empty_q ? '0 : mem[rptr_q];
  assign data_valid = ~empty_q;
`else
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= w_rd_acc;
      if (w_rd_acc) data_out_q <= mem[rptr_q];
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire
